// File: rtl/risc_pkg.sv
// Shared definitions for the instruction memory responder: NOP encoding,
// loader FSM state type and the default memory depth.
package risc_pkg;

    // Default number of 32-bit instruction words held by the responder.
    localparam int unsigned DEPTH_DEFAULT = 64;

    // RISC-V canonical NOP (addi x0, x0, 0), returned for unwritten addresses.
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Loader state: IDLE holds the core in reset, LOAD streams bytes in,
    // RUN releases the core.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

endpackage : risc_pkg

// File: rtl/imem_byte_assembler.sv
// Assembles a little-endian byte stream into 32-bit words. The byte arriving
// in the 4th lane completes the word; word_o already includes that byte so
// the word can be written on the same clock edge the byte is accepted.
module imem_byte_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  byte_idx_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  byte_idx_q;
    logic [31:0] asm_q;

    // Overlay the incoming byte on its lane so the completed word is available combinationally.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        word_o       = asm_q;
        word_valid_o = byte_valid_i && (byte_idx_q == 2'd3);
        if (byte_valid_i) begin
            word_o[{byte_idx_q, 3'b000} +: 8] = byte_i;
        end
    end

    assign byte_idx_o = byte_idx_q;

    // Track the lane index and capture partial words; clear drops any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            byte_idx_q <= 2'd0;
            asm_q      <= '0;
        end else if (clear_i) begin
            byte_idx_q <= 2'd0;
            asm_q      <= '0;
        end else if (byte_valid_i) begin
            if (byte_idx_q == 2'd3) begin
                byte_idx_q <= 2'd0;
                asm_q      <= '0;
            end else begin
                byte_idx_q <= byte_idx_q + 2'd1;
                asm_q      <= word_o;
            end
        end
    end

endmodule : imem_byte_assembler

// File: rtl/instr_mem_responder.sv
// Instruction memory with a byte-stream program loader. Holds the core in
// reset until a load completes, then serves instructions combinationally.
// Optional feature: define IMEM_CHECKSUM_EN to add a running XOR checksum
// output of all words written since the last load entry.
module instr_mem_responder
    import risc_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  imem_addr,
    output logic [31:0] imem_data,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    input  logic        load_end,
    output logic        core_rst_n,
    output logic        load_err,
    output logic [8:0]  word_count
`ifdef IMEM_CHECKSUM_EN
    ,
    output logic [31:0] checksum
`endif
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [8:0]  DEPTH_W = 9'(DEPTH);

    state_e      state_q, state_d;
    logic        core_rst_n_q;
    logic        load_err_q;
    logic [8:0]  word_count_q;
    logic [31:0] mem_q [DEPTH];

    logic        in_load;
    logic        full;
    logic        byte_fire;
    logic        overflow;
    logic        partial_after;
    logic        end_partial;
    logic        load_exit;
    logic        asm_clear;
    logic [1:0]  byte_idx;
    logic        word_valid;
    logic [31:0] word;

    imem_byte_assembler u_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (asm_clear),
        .byte_valid_i(byte_fire),
        .byte_i      (load_byte),
        .byte_idx_o  (byte_idx),
        .word_valid_o(word_valid),
        .word_o      (word)
    );

    // Decide byte acceptance, overflow, end-of-load handling and next state.
    // load_start takes priority everywhere and (re)enters LOAD.
    always_comb begin
        in_load       = (state_q == LOAD) && !load_start;
        full          = (word_count_q == DEPTH_W);
        byte_fire     = in_load && load_valid && !full;
        overflow      = in_load && load_valid && full;
        // Lane index as it stands after this cycle's byte, if any.
        partial_after = byte_fire ? (byte_idx != 2'd3) : (byte_idx != 2'd0);
        end_partial   = in_load && load_end && partial_after;
        load_exit     = in_load && (load_end || overflow);
        asm_clear     = load_start || load_exit;
        state_d       = state_q;
        if (load_start) begin
            state_d = LOAD;
        end else if (load_exit) begin
            state_d = RUN;
        end
    end

    // Loader FSM with registered core reset, word counter, sticky error and checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            core_rst_n_q <= 1'b0;
            word_count_q <= '0;
            load_err_q   <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            core_rst_n_q <= (state_d == RUN);
            if (load_start) begin
                word_count_q <= '0;
                load_err_q   <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
                checksum     <= '0;
`endif
            end else begin
                if (word_valid) begin
                    word_count_q <= word_count_q + 9'd1;
`ifdef IMEM_CHECKSUM_EN
                    checksum     <= checksum ^ word;
`endif
                end
                if (overflow || end_partial) begin
                    load_err_q <= 1'b1;
                end
            end
        end
    end

    // Write the completed word at the current count; a full memory never fires a write.
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset; word_count gating makes stale contents unreadable.
        if (word_valid) begin
            mem_q[word_count_q[AW-1:0]] <= word;
        end
    end

    // Zero-latency read; addresses at or beyond the loaded count return NOP.
    always_comb begin
        imem_data = NOP;
        if ({1'b0, imem_addr} < word_count_q) begin
            imem_data = mem_q[imem_addr[AW-1:0]];
        end
    end

    assign core_rst_n = core_rst_n_q;
    assign load_err   = load_err_q;
    assign word_count = word_count_q;

endmodule : instr_mem_responder

// File: tb/tb_instr_mem_responder.sv
// Directed testbench for instr_mem_responder (default DEPTH = 64).
module tb_instr_mem_responder;
    import risc_pkg::*;

    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  imem_addr = 8'd0;
    logic [31:0] imem_data;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_byte = 8'd0;
    logic        load_end = 1'b0;
    logic        core_rst_n;
    logic        load_err;
    logic [8:0]  word_count;
`ifdef IMEM_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int checks = 0;
    int passes = 0;

    instr_mem_responder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .load_start(load_start),
        .load_valid(load_valid),
        .load_byte (load_byte),
        .load_end  (load_end),
        .core_rst_n(core_rst_n),
        .load_err  (load_err),
        .word_count(word_count)
`ifdef IMEM_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        cycle();
        load_start = 1'b0;
    endtask

    task automatic pulse_end();
        load_end = 1'b1;
        cycle();
        load_end = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        cycle();
        load_valid = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        imem_addr = addr;
        #1;
        check(tag, imem_data, exp);
    endtask

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #2;
        read_check("rst_read0", 8'd0, NOP);
        check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        check("idle_core_rst_n", 32'(core_rst_n), 32'd0);

        // Single-word load: 93 00 10 00 -> 0x00100093
        pulse_start();
        send_byte(8'h93);
        send_byte(8'h00);
        send_byte(8'h10);
        check("load_core_rst_n_low", 32'(core_rst_n), 32'd0);
        send_byte(8'h00);
        check("w1_count_before_end", 32'(word_count), 32'd1);
        pulse_end();
        check("w1_core_rst_n", 32'(core_rst_n), 32'd1);
        check("w1_word_count", 32'(word_count), 32'd1);
        check("w1_load_err", 32'(load_err), 32'd0);
        read_check("w1_read0", 8'd0, 32'h0010_0093);
        read_check("w1_read1_nop", 8'd1, NOP);

        // RUN -> LOAD, one word plus a 2-byte partial word
        pulse_start();
        check("reload_core_rst_n", 32'(core_rst_n), 32'd0);
        check("reload_count_clr", 32'(word_count), 32'd0);
        read_check("reload_read0_nop", 8'd0, NOP);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'hAA);
        send_byte(8'hBB);
        pulse_end();
        check("partial_word_count", 32'(word_count), 32'd1);
        check("partial_load_err", 32'(load_err), 32'd1);
        check("partial_core_rst_n", 32'(core_rst_n), 32'd1);
        read_check("partial_read0", 8'd0, 32'h0403_0201);
        read_check("partial_read1_nop", 8'd1, NOP);

        // load_valid and load_end together on the 4th byte
        pulse_start();
        check("entry_err_clr", 32'(load_err), 32'd0);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        load_end = 1'b1;
        send_byte(8'h44);
        load_end = 1'b0;
        check("same_word_count", 32'(word_count), 32'd1);
        check("same_load_err", 32'(load_err), 32'd0);
        check("same_core_rst_n", 32'(core_rst_n), 32'd1);
        read_check("same_read0", 8'd0, 32'h4433_2211);

        // Overflow: 4*DEPTH bytes fill memory, the next byte is ignored
        pulse_start();
        for (int w = 0; w < int'(DEPTH); w++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(8'(w));
            end
        end
        check("full_word_count", 32'(word_count), 32'(DEPTH));
        check("full_still_load", 32'(core_rst_n), 32'd0);
        check("full_load_err", 32'(load_err), 32'd0);
        send_byte(8'hEE);
        check("ovf_word_count", 32'(word_count), 32'(DEPTH));
        check("ovf_load_err", 32'(load_err), 32'd1);
        check("ovf_auto_run", 32'(core_rst_n), 32'd1);
        read_check("ovf_read5", 8'd5, 32'h0505_0505);
        read_check("ovf_read63", 8'd63, 32'h3F3F_3F3F);
        read_check("ovf_read64_nop", 8'd64, NOP);

        // Reset asserted during the 2nd byte of a load
        pulse_start();
        send_byte(8'h55);
        load_valid = 1'b1;
        load_byte  = 8'h66;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_core_rst_n", 32'(core_rst_n), 32'd0);
        check("midrst_word_count", 32'(word_count), 32'd0);
        check("midrst_load_err", 32'(load_err), 32'd0);
        read_check("midrst_read0_nop", 8'd0, NOP);
        load_valid = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        send_byte(8'h77);
        pulse_end();
        check("postrst_idle_core", 32'(core_rst_n), 32'd0);
        check("postrst_idle_count", 32'(word_count), 32'd0);

        // Two-word load; new word becomes readable only after its write edge
        pulse_start();
        for (int b = 0; b < 4; b++) send_byte(8'h11);
        for (int b = 0; b < 3; b++) send_byte(8'h22);
        load_valid = 1'b1;
        load_byte  = 8'h22;
        read_check("wr_same_cycle_nop", 8'd1, NOP);
        cycle();
        load_valid = 1'b0;
        read_check("wr_next_cycle", 8'd1, 32'h2222_2222);
        pulse_end();
        check("two_word_count", 32'(word_count), 32'd2);
        check("two_core_rst_n", 32'(core_rst_n), 32'd1);
        read_check("two_read0", 8'd0, 32'h1111_1111);
`ifdef IMEM_CHECKSUM_EN
        check("checksum", checksum, 32'h3333_3333);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_instr_mem_responder

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit instruction words (power of two, max 256).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imem_addr  input  8  word address driven by the core PC.
REQ-005 SHALL have port imem_data  output  32  instruction word returned to the core.
REQ-006 SHALL have port load_start  input  1  pulse, begin a program load.
REQ-007 SHALL have port load_valid  input  1  load_byte is valid this cycle.
REQ-008 SHALL have port load_byte  input  8  program byte, little-endian within each word.
REQ-009 SHALL have port load_end  input  1  pulse, terminate the load.
REQ-010 SHALL have port core_rst_n  output  1  active-low reset to the core; low while not RUN.
REQ-011 SHALL have port load_err  output  1  sticky: partial word discarded or overflow.
REQ-012 SHALL have port word_count  output  9  number of words written by the last load.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN.
REQ-014 IDLE: core_rst_n=0; load_start -> LOAD; otherwise stay.
REQ-015 On the IDLE->LOAD or RUN->LOAD transition, SHALL clear word_count, byte index, and load_err.
REQ-016 LOAD: core_rst_n=0; each load_valid cycle shifts load_byte into lane (byte index) of the assembly register, byte index 0..3.
REQ-017 On the 4th byte, SHALL write the assembled word to mem[word_count] in that same clock edge, increment word_count, and reset the byte index to 0.
REQ-018 load_end in LOAD SHALL go to RUN next cycle; if byte index != 0, the partial word SHALL be dropped and load_err set.
REQ-019 load_valid and load_end in the same cycle SHALL accept the byte first, then end, with the REQ-018 check applied after the byte.
REQ-020 A byte arriving when word_count==DEPTH SHALL be ignored, set load_err, and force LOAD->RUN.
REQ-021 load_start during LOAD SHALL restart the load per REQ-015; existing memory contents are not cleared.
REQ-022 RUN: core_rst_n=1; load_start -> LOAD with core_rst_n low in the next cycle.
REQ-023 Read path SHALL be combinational, zero latency: imem_data = mem[imem_addr] when imem_addr < word_count, else NOP 32'h00000013.
REQ-024 A write and a read of the same address in the same cycle SHALL return the old word; the new word is visible next cycle.
REQ-025 core_rst_n SHALL be a registered output (glitch-free).

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, core_rst_n=0, word_count=0, load_err=0, byte index=0, and assembly register=0.
REQ-027 Memory array SHALL NOT be reset; with word_count=0, all reads return NOP.
REQ-028 Reset mid-LOAD SHALL discard the load in progress; a new load_start is required.

Configuration
REQ-029 Macro IMEM_CHECKSUM_EN: when defined, SHALL add output checksum[31:0] equal to the XOR of all words written since the last LOAD entry, cleared on entry and on reset.
REQ-030 Without IMEM_CHECKSUM_EN, the checksum port and its logic SHALL be absent.

Structure
REQ-031 Shared package risc_pkg SHALL hold the NOP constant, the FSM state typedef, and the DEPTH default.
REQ-032 Sub-module imem_byte_assembler SHALL contain the byte index and assembly register, and emit word_valid and word.

Verification
REQ-033 Reset, then read addr 0 -> imem_data=32'h00000013; core_rst_n=0; word_count=0.
REQ-034 load_start; bytes 93,00,10,00 (hex); load_end -> mem[0]=32'h00100093, word_count=1, RUN, core_rst_n=1, load_err=0.
REQ-035 Load 1 word plus 2 bytes, then load_end -> word_count=1, load_err=1, addr 1 reads NOP.
REQ-036 Load 4*DEPTH+1 bytes -> word_count=DEPTH, load_err=1, auto RUN, last byte ignored.
REQ-037 load_valid and load_end together on the 4th byte -> word written, load_err=0, RUN.
REQ-038 rst_n low during the 2nd byte of a load -> IDLE immediately, word_count=0; with IMEM_CHECKSUM_EN, after loading 32'h11111111 and 32'h22222222 -> checksum=32'h33333333.
